// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low (0 = segment lit).
package seg7_scan_driver_pkg;

  // All segments dark, and the dash shown for non-BCD codes.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Digit glyphs 0..9.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Decimal point levels (active low).
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Pin-level drive for the currently scanned digit.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_drive_t;

  localparam seg_drive_t DRIVE_OFF = '{seg: SEG_OFF, dp: DP_OFF};

endpackage : seg7_scan_driver_pkg

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not BCD and are shown as a dash so bad counter data is visible.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; the dash default covers every non-BCD code.
  always_comb begin
    // NOTE: assign a default before the case so no input value can leave seg_o
    // unassigned and infer a latch.
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule : bcd_to_seg7

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver for NUM_DIGITS BCD digits.
// Digits are captured into a shadow register on `update` and copied to the
// display register only when the scan wraps to digit 0, so a frame never tears.
// Each digit slot lasts DIV clocks and begins with GAP_CYC clocks of all anodes
// off to hide ghosting while the segment lines settle. All pin outputs are
// registered, one clock behind the scan counters.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    update,
  input  logic                    blank_lead,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  // Clocks per digit slot and counter widths.
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] GAP_END  = PRE_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan counters.
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_tick;
  logic             frame_wrap;

  // Captured and displayed digit data, one nibble per digit.
  logic [NUM_DIGITS-1:0][3:0] shadow_digits_q;
  logic [NUM_DIGITS-1:0]      shadow_dp_q;
  logic [NUM_DIGITS-1:0][3:0] display_digits_q;
  logic [NUM_DIGITS-1:0]      display_dp_q;

  // Leading-zero blanking mask over the displayed digits.
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_run;

  // Current digit selection and decode.
  logic [3:0] cur_digit;
  logic [6:0] cur_glyph;

  // Registered pin outputs and their next values.
  seg_drive_t            drive_q, drive_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------

  assign slot_tick  = (pre_q == PRE_LAST);
  assign frame_wrap = slot_tick && (idx_q == IDX_LAST);

  // Next prescaler and slot index: prescaler wraps every DIV clocks, the slot
  // index advances once per prescaler wrap and wraps after the last digit.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (slot_tick) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan counter registers and the frame pulse that follows the wrap tick.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: state flops are written with non-blocking assignments so every
      // register samples pre-edge values and the update order does not matter.
      pre_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit capture
  // ---------------------------------------------------------------------------

  // Shadow captures on the strobe; display copies the shadow only at the frame
  // wrap. An update on the wrap clock itself lands one frame later because the
  // display samples the shadow's value from before that edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: these digit registers are reset (unlike a RAM) because the value
      // shown right after reset is visible on the pins and must be a known 0.
      shadow_digits_q  <= '0;
      shadow_dp_q      <= '0;
      display_digits_q <= '0;
      display_dp_q     <= '0;
    end else begin
      if (update) begin
        shadow_digits_q <= digits_in;
        shadow_dp_q     <= dp_in;
      end
      if (frame_wrap) begin
        display_digits_q <= shadow_digits_q;
        display_dp_q     <= shadow_dp_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking
  // ---------------------------------------------------------------------------

  // Walk from the most significant digit down; a digit is blanked while every
  // digit from it upward is zero. Digit 0 is never blanked so a zero value
  // still shows a single '0'.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (display_digits_q[k] == 4'd0);
      blank_mask[k] = blank_lead && zero_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------

  assign cur_digit = display_digits_q[idx_q];

  bcd_to_seg7 u_decode (
    .bcd_i (cur_digit),
    .seg_o (cur_glyph)
  );

  // Next pin values: dark during the anti-ghost gap, otherwise enable the
  // scanned anode and drive its glyph (or blank) plus its decimal point.
  always_comb begin
    drive_d = DRIVE_OFF;
    an_d    = '1;
    if (pre_q >= GAP_END) begin
      an_d        = ~(NUM_DIGITS'(1) << idx_q);
      drive_d.seg = blank_mask[idx_q] ? SEG_OFF : cur_glyph;
      drive_d.dp  = display_dp_q[idx_q] ? DP_ON : DP_OFF;
    end
  end

  // Registered pin drivers so segment and anode lines change on the same edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      drive_q <= DRIVE_OFF;
      an_q    <= '1;
    end else begin
      drive_q <= drive_d;
      an_q    <= an_d;
    end
  end

  assign seg        = drive_q.seg;
  assign dp         = drive_q.dp;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at CLK_HZ=1000, SCAN_HZ=100 (DIV=10),
// NUM_DIGITS=4, GAP_CYC=2. Stimulus pushes the expected slot contents of a
// frame when that frame starts; a monitor pops one entry at every slot start.
module tb_seg7_scan_driver;

  localparam int DIV   = 10;
  localparam int FRAME = 4 * DIV;
  localparam int GAP   = 2;

  logic        clk;
  logic        clr_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        update;
  logic        blank_lead;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .NUM_DIGITS (4),
    .GAP_CYC    (2)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .update     (update),
    .blank_lead (blank_lead),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         slot;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: frame period, anode exclusivity, and per-slot scoreboard compare.
  int fcnt    = 0;
  int off_run = 0;
  bit have_tick = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!clr_n) begin
      have_tick = 1'b0;
      off_run   = 0;
      fcnt      = 0;
    end else begin
      if (frame_tick) begin
        if (have_tick) check("frame_period", fcnt + 1, FRAME);
        have_tick = 1'b1;
        fcnt      = 0;
      end else begin
        fcnt++;
      end
      check("an_at_most_one_low", int'($countones(~an) <= 1), 1);
      if (an != 4'hF) begin
        if (off_run > 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("slot%0d_an", e.slot), int'(an), int'(e.an));
          check($sformatf("slot%0d_seg", e.slot), int'(seg), int'(e.seg));
          check($sformatf("slot%0d_dp", e.slot), int'(dp), int'(e.dp));
          check($sformatf("slot%0d_start", e.slot), fcnt, GAP + 1 + DIV * e.slot);
          check($sformatf("slot%0d_gap", e.slot), off_run, GAP);
        end
        off_run = 0;
      end else begin
        off_run++;
      end
    end
  end

  // Expected frame: glyphs for digits 0..3 and active-low dp levels per digit.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpn);
    exp_q.push_back('{an: 4'hE, seg: s0, dp: dpn[0], slot: 0});
    exp_q.push_back('{an: 4'hD, seg: s1, dp: dpn[1], slot: 1});
    exp_q.push_back('{an: 4'hB, seg: s2, dp: dpn[2], slot: 2});
    exp_q.push_back('{an: 4'h7, seg: s3, dp: dpn[3], slot: 3});
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      seen = frame_tick;
    end
    if (!seen) check("frame_tick_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_update(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    digits_in = d;
    dp_in     = p;
    update    = 1'b1;
    @(negedge clk);
    update    = 1'b0;
  endtask

  // After a release at a negedge: dark for GAP clocks, then digit 0 shows '0'.
  task automatic check_restart(input string tag);
    @(negedge clk);
    check({tag, "_an_clk1"}, int'(an), 4'hF);
    @(negedge clk);
    check({tag, "_an_clk2"}, int'(an), 4'hF);
    @(negedge clk);
    check({tag, "_an_clk3"}, int'(an), 4'hE);
    check({tag, "_seg_clk3"}, int'(seg), 7'h40);
    check({tag, "_dp_clk3"}, int'(dp), 1);
  endtask

  initial begin
    int n;
    clr_n      = 1'b0;
    digits_in  = '0;
    dp_in      = '0;
    update     = 1'b0;
    blank_lead = 1'b0;

    // 1: reset values, then restart timing.
    repeat (3) @(negedge clk);
    check("rst_seg", int'(seg), 7'h7F);
    check("rst_dp", int'(dp), 1);
    check("rst_an", int'(an), 4'hF);
    check("rst_frame_tick", int'(frame_tick), 0);
    clr_n = 1'b1;
    check_restart("rel");

    // 2: 1234 -> slots an=E/19, D/30, B/24, 7/79.
    do_update(16'h1234, 4'b0000);
    wait_frame();
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
    wait_drain();

    // 3: leading-zero blanking on 0090, then disabled, then an all-zero value.
    blank_lead = 1'b1;
    do_update(16'h0090, 4'b0000);
    wait_frame();
    push_frame(7'h40, 7'h10, 7'h7F, 7'h7F, 4'hF);
    wait_drain();
    blank_lead = 1'b0;
    wait_frame();
    push_frame(7'h40, 7'h10, 7'h40, 7'h40, 4'hF);
    wait_drain();
    blank_lead = 1'b1;
    do_update(16'h0000, 4'b0000);
    wait_frame();
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    wait_drain();

    // 4: non-BCD codes show a dash; dp follows dp_in, also on a blanked digit.
    blank_lead = 1'b0;
    do_update(16'h00AF, 4'b0010);
    wait_frame();
    push_frame(7'h3F, 7'h3F, 7'h40, 7'h40, 4'b1101);
    wait_drain();
    blank_lead = 1'b1;
    do_update(16'h0000, 4'b1000);
    wait_frame();
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0111);
    wait_drain();

    // 5: frame sync. Mid-frame update holds until the wrap; an update on the
    // wrap clock itself is deferred by one frame.
    blank_lead = 1'b0;
    wait_frame();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0111);
    repeat (14) @(negedge clk);
    digits_in = 16'h6789;
    dp_in     = 4'b0000;
    update    = 1'b1;
    @(negedge clk);
    update    = 1'b0;
    repeat (FRAME - 16) @(negedge clk);
    digits_in = 16'h5555;
    update    = 1'b1;
    @(negedge clk);
    update    = 1'b0;
    check("wrap_update_aligned", int'(frame_tick), 1);
    push_frame(7'h10, 7'h00, 7'h78, 7'h02, 4'hF);
    wait_frame();
    push_frame(7'h12, 7'h12, 7'h12, 7'h12, 4'hF);
    wait_drain();

    // 6: asynchronous reset in slot 2 at pre=5, then a clean restart from idx 0.
    wait_frame();
    repeat (2 * DIV + 5) @(negedge clk);
    check("pre_reset_an", int'(an), 4'hB);
    #2 clr_n = 1'b0;
    #1;
    check("async_rst_an", int'(an), 4'hF);
    check("async_rst_seg", int'(seg), 7'h7F);
    check("async_rst_dp", int'(dp), 1);
    check("async_rst_frame_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    check_restart("rerel");
    n = 3;
    while (!frame_tick && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("restart_first_frame_tick", n, FRAME);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=%0t required<100000", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_seg7_scan_driver
